// File: rtl/mem_dump.sv
// mem_dump: reads a contiguous word range through the sync read port and streams it out.
// Optional MEM_DUMP_CHECKSUM_EN appends a 32-bit running-sum word to the stream.
module mem_dump #(
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             io_start,
    input  logic             io_abort,
    input  logic [63:0]      io_baseAddr,
    input  logic [CNT_W-1:0] io_wordCount,
    output logic             io_busy,
    output logic             io_done,
    output logic             io_rdEn,
    output logic [63:0]      io_rdAddr,
    input  logic [31:0]      io_rdData,
    output logic             io_out_valid,
    input  logic             io_out_ready,
    output logic [31:0]      io_out_bits,
    output logic             io_out_last
);
    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
    state_t           state;
    logic [63:0]      base;
    logic [CNT_W-1:0] count, issued, popped;
    logic             in_flight, rd_ptr, wr_ptr;
    logic [1:0]       occ;
    logic [31:0]      fifo [2];
    logic [31:0]      head;
    logic             live, data_valid, pop, fifo_pop, push;

    assign live       = state == RUN && !io_abort;
    assign io_busy    = state != IDLE;
    assign io_done    = state == FIN && !io_abort;
    assign io_rdEn    = live && issued != count && occ + {1'b0, in_flight} < 2'd2;
    assign io_rdAddr  = base + {{(62 - CNT_W){1'b0}}, issued, 2'b00};
    // Read data arriving into an empty FIFO is presented straight away (write-through).
    assign data_valid = state == RUN && (occ != 2'd0 || in_flight);
    assign head       = occ == 2'd0 ? io_rdData : fifo[rd_ptr];
    assign pop        = io_out_valid && io_out_ready;
    assign fifo_pop   = pop && occ != 2'd0;
    assign push       = in_flight && !(pop && occ == 2'd0);

`ifdef MEM_DUMP_CHECKSUM_EN
    logic [31:0] sum;
    logic        sum_word;
    assign sum_word     = state == RUN && popped == count;
    assign io_out_valid = data_valid || sum_word;
    assign io_out_bits  = data_valid ? head : sum_word ? sum : 32'd0;
    assign io_out_last  = sum_word;
`else
    assign io_out_valid = data_valid;
    assign io_out_bits  = data_valid ? head : 32'd0;
    assign io_out_last  = data_valid && popped == count - 1'b1;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            base      <= '0;
            count     <= '0;
            issued    <= '0;
            popped    <= '0;
            in_flight <= 1'b0;
            occ       <= '0;
            rd_ptr    <= 1'b0;
            wr_ptr    <= 1'b0;
`ifdef MEM_DUMP_CHECKSUM_EN
            sum       <= '0;
`endif
        end else if (io_abort && state != IDLE) begin
            state     <= IDLE;
            issued    <= '0;
            popped    <= '0;
            in_flight <= 1'b0;
            occ       <= '0;
            rd_ptr    <= 1'b0;
            wr_ptr    <= 1'b0;
        end else begin
            in_flight <= io_rdEn;
            case (state)
                IDLE: if (io_start) begin
                    base   <= io_baseAddr & ~64'd3;
                    count  <= io_wordCount;
                    issued <= '0;
                    popped <= '0;
                    occ    <= '0;
                    rd_ptr <= 1'b0;
                    wr_ptr <= 1'b0;
`ifdef MEM_DUMP_CHECKSUM_EN
                    sum    <= '0;
                    state  <= RUN;
`else
                    state  <= io_wordCount == '0 ? FIN : RUN;
`endif
                end
                RUN: begin
                    if (io_rdEn) issued <= issued + 1'b1;
                    if (push) begin
                        fifo[wr_ptr] <= io_rdData;
                        wr_ptr       <= !wr_ptr;
                    end
                    if (fifo_pop) rd_ptr <= !rd_ptr;
                    occ <= occ + {1'b0, push} - {1'b0, fifo_pop};
                    if (pop) popped <= popped + 1'b1;
`ifdef MEM_DUMP_CHECKSUM_EN
                    if (pop) sum <= sum + io_out_bits;
`endif
                    if (pop && io_out_last) state <= FIN;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_dump.sv
// tb_mem_dump: randomized dumps checked against a queue-based model of the expected stream.
module tb_mem_dump;
    localparam int CNT_W = 16;
    logic             clock = 1'b0;
    logic             reset, io_start, io_abort, io_out_ready;
    logic [63:0]      io_baseAddr;
    logic [CNT_W-1:0] io_wordCount;
    logic             io_busy, io_done, io_rdEn, io_out_valid, io_out_last;
    logic [63:0]      io_rdAddr;
    logic [31:0]      rd_data, io_out_bits;

    int checks = 0, failures = 0, cyc = 0;
    int start_cyc, done_seen, pops, issued_n, exp_done, cur_n;
    bit active = 0, timing, first_rd, first_valid, prev_stall;
    logic [32:0] prev_word;
    logic [63:0] exp_addr [$];
    logic [32:0] exp_out [$];
    logic [31:0] mem_ovr [logic [63:0]];

    always #5 clock = ~clock;

    mem_dump #(.CNT_W(CNT_W)) dut (
        .clock(clock), .reset(reset), .io_start(io_start), .io_abort(io_abort),
        .io_baseAddr(io_baseAddr), .io_wordCount(io_wordCount), .io_busy(io_busy),
        .io_done(io_done), .io_rdEn(io_rdEn), .io_rdAddr(io_rdAddr), .io_rdData(rd_data),
        .io_out_valid(io_out_valid), .io_out_ready(io_out_ready), .io_out_bits(io_out_bits),
        .io_out_last(io_out_last)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        if (mem_ovr.exists(a)) return mem_ovr[a];
        return a[33:2] ^ a[63:32] ^ 32'h6b3c_91d5;
    endfunction

    // Synchronous memory: data one cycle after the strobe, garbage otherwise.
    always @(posedge clock) begin
        cyc     <= cyc + 1;
        rd_data <= io_rdEn ? mem_word(io_rdAddr) : $urandom;
    end

    always @(negedge clock) begin
        int rel;
        if (io_done) done_seen++;
        if (active) begin
            rel = cyc - start_cyc;
            check("busy", 64'(io_busy), 64'd1);
            if (io_abort) check("abort_rd_en", 64'(io_rdEn), 64'd0);
            if (io_rdEn) begin
                issued_n++;
                if (exp_addr.size() == 0) check("rd_unexpected", 64'(io_rdEn), 64'd0);
                else check("rd_addr", io_rdAddr, exp_addr.pop_front());
                check("outstanding_le_2", 64'(issued_n - pops <= 2), 64'd1);
                if (timing && !first_rd) check("first_rd_cyc", 64'(rel), 64'd1);
                first_rd = 1;
            end
            if (prev_stall) begin
                check("stall_valid", 64'(io_out_valid), 64'd1);
                check("stall_word", 64'({io_out_last, io_out_bits}), 64'(prev_word));
            end
            if (io_out_valid && timing && cur_n > 0 && !first_valid) check("first_valid_cyc", 64'(rel), 64'd2);
            if (io_out_valid) first_valid = 1;
            if (io_out_valid && io_out_ready) begin
                if (exp_out.size() == 0) check("out_unexpected", 64'(io_out_valid), 64'd0);
                else check("out_word", 64'({io_out_last, io_out_bits}), 64'(exp_out.pop_front()));
                pops++;
            end
            if (io_done && timing) check("done_cyc", 64'(rel), 64'(exp_done));
            prev_stall = io_out_valid && !io_out_ready;
            prev_word  = {io_out_last, io_out_bits};
        end
    end

    // mode 0: ready high, 1: ready 1,0,0 repeating, 2: random ready.
    task automatic run_dump(input logic [63:0] b, input int n, input int mode, input int stop_after, input bit use_reset);
        logic [63:0] a;
        logic [31:0] s;
        bit stopped;
        s = 0;
        exp_addr.delete();
        exp_out.delete();
        for (int i = 0; i < n; i++) begin
            a = (b & ~64'd3) + 64'(4 * i);
            exp_addr.push_back(a);
            s += mem_word(a);
`ifdef MEM_DUMP_CHECKSUM_EN
            exp_out.push_back({1'b0, mem_word(a)});
`else
            exp_out.push_back({i == n - 1, mem_word(a)});
`endif
        end
`ifdef MEM_DUMP_CHECKSUM_EN
        exp_out.push_back({1'b1, s});
        exp_done = n == 0 ? 2 : n + 3;
`else
        exp_done = n == 0 ? 1 : n + 2;
`endif
        timing       = mode == 0 && stop_after < 0;
        cur_n        = n;
        io_start     = 1;
        io_baseAddr  = b;
        io_wordCount = CNT_W'(n);
        @(posedge clock); #1;
        io_start     = 0;
        io_baseAddr  = {$urandom, $urandom};
        io_wordCount = CNT_W'($urandom);
        start_cyc    = cyc - 1;
        done_seen    = 0;
        pops         = 0;
        issued_n     = 0;
        first_rd     = 0;
        first_valid  = 0;
        prev_stall   = 0;
        stopped      = 0;
        active       = 1;
        for (int c = 0; c < 3000 && done_seen == 0 && !stopped; c++) begin
            io_out_ready = mode == 0 ? 1'b1 : mode == 1 ? (c % 3 == 0) : 1'($urandom_range(0, 1));
            if (stop_after >= 0 && pops == stop_after) begin
                io_out_ready = 0;
                if (use_reset) reset = 1;
                else io_abort = 1;
                stopped = 1;
            end
            @(posedge clock); #1;
            reset    = 0;
            io_abort = 0;
        end
        active = 0;
        check("busy_after", 64'(io_busy), 64'd0);
        if (stopped) begin
            check("valid_after_stop", 64'(io_out_valid), 64'd0);
            if (use_reset) check("rd_addr_after_reset", io_rdAddr, 64'd0);
            repeat (4) @(posedge clock);
            #1;
            check("no_done_after_stop", 64'(done_seen), 64'd0);
        end else begin
            @(posedge clock); #1;
            check("done_once", 64'(done_seen), 64'd1);
            check("out_left", 64'(exp_out.size()), 64'd0);
            check("addr_left", 64'(exp_addr.size()), 64'd0);
        end
    endtask

    initial begin
        logic [63:0] b;
        int n, mode;
        reset        = 1;
        io_start     = 0;
        io_abort     = 0;
        io_out_ready = 0;
        io_baseAddr  = '0;
        io_wordCount = '0;
        repeat (2) @(posedge clock);
        #1;
        check("rst_busy", 64'(io_busy), 64'd0);
        check("rst_done", 64'(io_done), 64'd0);
        check("rst_rd_en", 64'(io_rdEn), 64'd0);
        check("rst_rd_addr", io_rdAddr, 64'd0);
        check("rst_valid", 64'(io_out_valid), 64'd0);
        check("rst_bits", 64'(io_out_bits), 64'd0);
        check("rst_last", 64'(io_out_last), 64'd0);
        reset = 0;
        @(posedge clock); #1;
        for (int i = 0; i < 8; i++) mem_ovr[64'h100 + 64'(4 * i)] = 32'h1000_0000 + 32'(i);
        mem_ovr[64'h400] = 32'h0000_0001;
        mem_ovr[64'h404] = 32'h0000_0002;
        mem_ovr[64'h408] = 32'hFFFF_FFFF;
        run_dump(64'h100, 4, 0, -1, 0);
        run_dump(64'h100, 4, 1, -1, 0);
        run_dump(64'h103, 4, 2, -1, 0);
        run_dump(64'h100, 0, 0, -1, 0);
        run_dump(64'hFFFF_FFFF_FFFF_FFF8, 3, 0, -1, 0);
        run_dump(64'h100, 8, 0, 2, 0);
        run_dump(64'h200, 1, 0, -1, 0);
        run_dump(64'h300, 6, 2, 3, 1);
        run_dump(64'h400, 3, 0, -1, 0);
        run_dump(64'h1000, 40, 1, -1, 0);
        for (int k = 0; k < 24; k++) begin
            b = {$urandom, $urandom};
            if (k % 4 == 0) b[63:8] = '1;
            n    = $urandom_range(0, 12);
            mode = $urandom_range(0, 2);
            if (k % 5 == 3 && n > 2) run_dump(b, n, mode, $urandom_range(0, n - 2), 1'($urandom_range(0, 1)));
            else run_dump(b, n, mode, -1, 0);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
